// File: rtl/fir_decim.sv
// Accumulate-and-dump decimator for the FIR output stream, with saturation and a small output FIFO.
// Build option: define FIR_DECIM_ROUND_EN to round half toward +inf instead of flooring.
module fir_decim #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 12,
  parameter int LOG2_DECIM = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [IN_W-1:0]        in_data,
  input  logic                          in_valid,
  output logic signed [OUT_W-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          ovf,
  input  logic                          clr_ovf
);

  localparam int ACC_W = IN_W + LOG2_DECIM;
  // One spare bit so the rounding bias can never wrap the block sum.
  localparam int SUM_W = ACC_W + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [LOG2_DECIM-1:0]  PHASE_LAST = '1;
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [AW:0]             FULL_CNT = (AW + 1)'(FIFO_DEPTH);
`ifdef FIR_DECIM_ROUND_EN
  localparam logic signed [SUM_W-1:0] ROUND_BIAS = SUM_W'(1) << (LOG2_DECIM - 1);
`endif

  logic [LOG2_DECIM-1:0]    phase;
  logic signed [ACC_W-1:0]  acc;
  logic signed [OUT_W-1:0]  res;
  logic                     res_valid;

  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  sum_adj;
  logic signed [SUM_W-1:0]  sum_shr;
  logic signed [OUT_W-1:0]  sat_val;
  logic                     produce;

  // NOTE: every variable written here gets a value before any branch, otherwise a latch is inferred.
  always_comb begin
    sum     = SUM_W'(acc) + SUM_W'(in_data);
`ifdef FIR_DECIM_ROUND_EN
    sum_adj = sum + ROUND_BIAS;
`else
    sum_adj = sum;
`endif
    sum_shr = sum_adj >>> LOG2_DECIM;
    sat_val = sum_shr[OUT_W-1:0];
    if (sum_shr > SAT_MAX) begin
      sat_val = SAT_MAX[OUT_W-1:0];
    end else if (sum_shr < SAT_MIN) begin
      sat_val = SAT_MIN[OUT_W-1:0];
    end
    produce = in_valid && (phase == PHASE_LAST);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= '0;
      acc       <= '0;
      res       <= '0;
      res_valid <= 1'b0;
    end else begin
      // A pending result is always consumed (pushed or dropped) on the next edge.
      res_valid <= produce;
      if (produce) begin
        res   <= sat_val;
        acc   <= '0;
        phase <= '0;
      end else if (in_valid) begin
        acc   <= sum[ACC_W-1:0];
        phase <= phase + 1'b1;
      end
    end
  end

  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_cnt;
  logic [AW:0]      rd_cnt;
  logic             full;
  logic             pop;
  logic             wr_en;
  logic             drop;

  assign fill      = wr_cnt - rd_cnt;
  assign out_valid = (wr_cnt != rd_cnt);
  assign full      = (fill == FULL_CNT);
  assign pop       = out_valid && out_ready;
  assign wr_en     = res_valid && (!full || pop);
  assign drop      = res_valid && full && !pop;
  assign out_data  = mem[rd_cnt[AW-1:0]];

  // NOTE: the storage is reset because out_data must read 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_cnt[AW-1:0]] <= res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (wr_en) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (pop) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  // Sticky drop flag; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  a_fill_bound : assert property (@(posedge clk) disable iff (rst) fill <= FULL_CNT);
  a_drop_flags : assert property (@(posedge clk) disable iff (rst) drop |=> ovf);

endmodule

// File: tb/tb_fir_decim.sv
// Scoreboard bench for fir_decim: a sample-level average model queues expected results,
// a negedge monitor pops and compares whenever the DUT hands one over.
module tb_fir_decim;

  localparam int DECIM      = 4;
  localparam int LOG2_DECIM = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic signed [11:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         fill;
  logic               ovf;
  logic               clr_ovf;

  int n_checks = 0;
  int n_pass   = 0;
  int sb[$];
  int m_sum    = 0;
  int m_cnt    = 0;
  bit m_drop   = 1'b0;
  int exp_v;

  always #5 clk = ~clk;

  fir_decim #(
    .IN_W(16), .OUT_W(12), .LOG2_DECIM(LOG2_DECIM), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fill(fill), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int model_avg(input int s);
    int t;
`ifdef FIR_DECIM_ROUND_EN
    t = (s + DECIM / 2) >>> LOG2_DECIM;
`else
    t = s >>> LOG2_DECIM;
`endif
    if (t > 2047)  t = 2047;
    if (t < -2048) t = -2048;
    return t;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int d);
    in_data  = 16'(d);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    m_sum += d;
    m_cnt++;
    if (m_cnt == DECIM) begin
      if (!m_drop) sb.push_back(model_avg(m_sum));
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  task automatic send_block(input int v);
    repeat (DECIM) send(v);
  endtask

  task automatic wait_drain();
    int i = 0;
    while ((sb.size() != 0 || out_valid) && i < 100) begin
      idle(1);
      i++;
    end
    check("drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", out_data, 99999);
      end else begin
        exp_v = sb.pop_front();
        check("out_data", out_data, exp_v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_fill", fill, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk) rst = 1'b0;
    idle(1);

    // Averaging and one-cycle push latency.
    out_ready = 1'b1;
    send(1); send(4); send(16); send(4);
    check("lat_edge_k", out_valid, 0);
    idle(1);
    check("lat_edge_k1", out_valid, 1);
    wait_drain();

    // Negative sum: floor vs round.
    send(-21); send(-25); send(-26); send(-26);
    wait_drain();

    // Saturation both ways.
    send_block(32767);
    send_block(-32768);
    send_block(8191);
    send_block(-8192);
    wait_drain();

    // Backpressure: fifth block is dropped.
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      m_drop = (v == 5);
      send_block(v);
    end
    m_drop = 1'b0;
    idle(2);
    check("full_fill", fill, 4);
    check("full_ovf", ovf, 1);
    out_ready = 1'b1;
    wait_drain();
    check("ovf_sticky", ovf, 1);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    check("ovf_cleared", ovf, 0);

    // Full FIFO with push and pop on the same edge.
    out_ready = 1'b0;
    for (int v = 10; v <= 13; v++) send_block(v);
    idle(2);
    check("full2_fill", fill, 4);
    send_block(14);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("pushpop_fill", fill, 4);
    check("pushpop_ovf", ovf, 0);
    out_ready = 1'b1;
    wait_drain();

    // Clear coinciding with a drop: set wins.
    out_ready = 1'b0;
    for (int v = 20; v <= 23; v++) send_block(v);
    idle(2);
    m_drop = 1'b1;
    send_block(24);
    m_drop = 1'b0;
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    check("ovf_set_wins", ovf, 1);
    out_ready = 1'b1;
    wait_drain();
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    check("ovf_cleared2", ovf, 0);

    // Gaps in in_valid; ignored samples carry junk data.
    for (int i = 0; i < 7; i++) begin
      if (i == 0 || i == 3 || i == 4 || i == 6) begin
        send(2);
      end else begin
        in_data = 16'sd100;
        in_valid = 1'b0;
        idle(1);
      end
    end
    wait_drain();

    // Asynchronous reset mid-block discards partial sum and FIFO contents.
    out_ready = 1'b0;
    m_drop = 1'b1;
    send_block(9);
    m_drop = 1'b0;
    idle(2);
    check("pre_rst_valid", out_valid, 1);
    send(7); send(7);
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_fill", fill, 0);
    m_sum = 0;
    m_cnt = 0;
    @(negedge clk) rst = 1'b0;
    idle(1);
    out_ready = 1'b1;
    send_block(8);
    wait_drain();
    check("final_ovf", ovf, 0);

    check("sb_final", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
